// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide engine. A request taken in IDLE (or DONE)
//   runs XLEN shift-add or restoring-divide iterations on operand magnitudes,
//   then one sign-correction/select cycle, then pulses MD_done for one cycle.
//   Start-to-result latency is XLEN+1 edges.
//
// Ports
//   SYS_clk       rising-edge clock
//   SYS_reset     asynchronous active-high reset
//   MD_start      request, sampled only while MD_busy is low
//   MD_funct3     RV32M funct3 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
//   MD_operand_a  rs1 value (multiplicand / dividend)
//   MD_operand_b  rs2 value (multiplier / divisor)
//   MD_busy       operation in progress (CALC or FIX)
//   MD_done       one-cycle pulse, MD_result valid
//   MD_result     final result, held until the next operation completes
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            MD_start,
  input  logic [2:0]      MD_funct3,
  input  logic [XLEN-1:0] MD_operand_a,
  input  logic [XLEN-1:0] MD_operand_b,
  output logic            MD_busy,
  output logic            MD_done,
  output logic [XLEN-1:0] MD_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              neg_q,    neg_d;     // product/quotient must be negated
  logic              a_neg_q,  a_neg_d;   // remainder takes dividend sign
  logic              bzero_q,  bzero_d;   // divisor was zero
  logic [XLEN-1:0]   opnd_q,   opnd_d;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q,    acc_d;     // {hi, lo} working register
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at the start edge
  logic            a_signed, b_signed, a_neg, b_neg, start_ok;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (MD_funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         a_signed = 1'b1;
      default:                        ;
    endcase
    a_neg = a_signed & MD_operand_a[XLEN-1];
    b_neg = b_signed & MD_operand_b[XLEN-1];
    a_mag = a_neg ? -MD_operand_a : MD_operand_a;
    b_mag = b_neg ? -MD_operand_b : MD_operand_b;
  end

  assign start_ok = MD_start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Multiply step: acc = {partial_hi, multiplier_remaining}; add the
  // multiplicand into the high half when the current multiplier bit is set,
  // then shift the whole register right (carry enters at the top).
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  // Divide step: acc = {remainder, dividend/quotient}; shift left one bit,
  // trial-subtract the divisor, keep the difference when it does not borrow.
  logic [XLEN:0]     div_rsh, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_rsh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_rsh - {1'b0, opnd_q};
    div_ok   = ~div_diff[XLEN];
    div_next = {(div_ok ? div_diff[XLEN-1:0] : div_rsh[XLEN-1:0]),
                acc_q[XLEN-2:0], div_ok};
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_result;

  always_comb begin
    prod_s = neg_q   ? -acc_q : acc_q;
    quo_s  = neg_q   ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (!funct3_q[2]) begin
      fix_result = (funct3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                            : prod_s[2*XLEN-1:XLEN];
    end else if (!funct3_q[1]) begin
      // Divide by zero yields all ones regardless of dividend sign. Signed
      // overflow (MIN / -1) already falls out as MIN with remainder 0.
      fix_result = bzero_q ? '1 : quo_s;
    end else begin
      // Remainder by zero: magnitude restored with the dividend sign gives
      // the original dividend back.
      fix_result = rem_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    bzero_d  = bzero_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      S_CALC: begin
        acc_d = funct3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_result;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        if (start_ok) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          funct3_d = MD_funct3;
          neg_d    = a_neg ^ b_neg;
          a_neg_d  = a_neg;
          bzero_d  = (MD_operand_b == '0);
          opnd_d   = MD_funct3[2] ? b_mag : a_mag;
          acc_d    = {{XLEN{1'b0}}, (MD_funct3[2] ? a_mag : b_mag)};
        end
      end
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      bzero_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      bzero_q  <= bzero_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign MD_busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign MD_done   = (state_q == S_DONE);
  assign MD_result = result_q;

endmodule
